// File: rtl/me_fullsearch_engine.sv
// Full-search block-matching engine: SAD of every candidate, minimum SAD with x/y vector.
// Optional early termination of losing candidates is built when ME_EARLY_TERM_EN is defined.
module me_fullsearch_engine #(
    parameter int TB_LENGTH = 16,
    parameter int SW_LENGTH = 64,
    parameter int PEL_WIDTH = 8,
    localparam int ADDR_SW   = (SW_LENGTH > 1) ? $clog2(SW_LENGTH * SW_LENGTH) : 1,
    localparam int ADDR_TB   = (TB_LENGTH > 1) ? $clog2(TB_LENGTH * TB_LENGTH) : 1,
    localparam int MV_WIDTH  = (SW_LENGTH - TB_LENGTH > 0) ? $clog2(SW_LENGTH - TB_LENGTH + 1) : 1,
    localparam int SAD_WIDTH = $clog2(TB_LENGTH * TB_LENGTH) + PEL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    output logic [ADDR_SW-1:0]   addr_sw,
    output logic [ADDR_TB-1:0]   addr_tb,
    input  logic [PEL_WIDTH-1:0] pel_sw,
    input  logic [PEL_WIDTH-1:0] pel_tb,
    output logic                 busy,
    output logic [SAD_WIDTH-1:0] min_sad,
    output logic [MV_WIDTH-1:0]  min_mvx,
    output logic [MV_WIDTH-1:0]  min_mvy,
    output logic                 ack
);

    localparam int MV_MAX = SW_LENGTH - TB_LENGTH;
    localparam int TW     = (TB_LENGTH > 1) ? $clog2(TB_LENGTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic [PEL_WIDTH-1:0] abs_diff(input logic [PEL_WIDTH-1:0] a,
                                                      input logic [PEL_WIDTH-1:0] b);
        logic signed [PEL_WIDTH:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[PEL_WIDTH] ? PEL_WIDTH'(-d) : d[PEL_WIDTH-1:0];
    endfunction

    state_t state, state_nxt;

    logic [TW-1:0]       tx, ty, tx_cur, ty_cur, tx_nxt, ty_nxt;
    logic [MV_WIDTH-1:0] mx, my, mx_cur, my_cur, mx_nxt, my_nxt;
    logic                start, issue, pix_last, cand_last, issue_last;
    logic                abort, abort_stop;

    logic                vld_p0, first_p0, last_p0;
    logic [MV_WIDTH-1:0] mvx_p0, mvy_p0;
    logic                vld_p1, first_p1, last_p1;
    logic [MV_WIDTH-1:0] mvx_p1, mvy_p1;
    logic                vld_p2;
    logic [MV_WIDTH-1:0] mvx_p2, mvy_p2;
    logic [SAD_WIDTH-1:0] acc_p2;

    logic [PEL_WIDTH-1:0] diff_p1;
    logic [SAD_WIDTH-1:0] partial_p1;
    logic                 min_valid, upd;

    assign start = (state == IDLE) && req;

    // Running SAD of the pixel returning this cycle; first pixel of a candidate loads directly.
    assign diff_p1    = abs_diff(pel_sw, pel_tb);
    assign partial_p1 = first_p1 ? SAD_WIDTH'(diff_p1) : acc_p2 + SAD_WIDTH'(diff_p1);

`ifdef ME_EARLY_TERM_EN
    // Abort only on a non-last pixel: then the single read in flight still belongs to this candidate.
    assign abort      = (state == RUN) && vld_p1 && !last_p1 && min_valid && (partial_p1 >= min_sad);
    assign abort_stop = abort && (mvx_p1 == MV_WIDTH'(MV_MAX)) && (mvy_p1 == MV_WIDTH'(MV_MAX));
`else
    assign abort      = 1'b0;
    assign abort_stop = 1'b0;
`endif

    always_comb begin
        tx_cur = tx;
        ty_cur = ty;
        mx_cur = mx;
        my_cur = my;
        if (state == IDLE) begin
            tx_cur = '0;
            ty_cur = '0;
            mx_cur = '0;
            my_cur = '0;
        end else if (abort) begin
            tx_cur = '0;
            ty_cur = '0;
            if (mvx_p1 == MV_WIDTH'(MV_MAX)) begin
                mx_cur = '0;
                my_cur = mvy_p1 + 1'b1;
            end else begin
                mx_cur = mvx_p1 + 1'b1;
                my_cur = mvy_p1;
            end
        end
    end

    assign issue      = start || ((state == RUN) && !abort_stop);
    assign pix_last   = (tx_cur == TW'(TB_LENGTH - 1)) && (ty_cur == TW'(TB_LENGTH - 1));
    assign cand_last  = (mx_cur == MV_WIDTH'(MV_MAX)) && (my_cur == MV_WIDTH'(MV_MAX));
    assign issue_last = issue && pix_last && cand_last;

    always_comb begin
        tx_nxt = tx_cur + 1'b1;
        ty_nxt = ty_cur;
        mx_nxt = mx_cur;
        my_nxt = my_cur;
        if (tx_cur == TW'(TB_LENGTH - 1)) begin
            tx_nxt = '0;
            ty_nxt = ty_cur + 1'b1;
            if (ty_cur == TW'(TB_LENGTH - 1)) begin
                ty_nxt = '0;
                mx_nxt = mx_cur + 1'b1;
                if (mx_cur == MV_WIDTH'(MV_MAX)) begin
                    mx_nxt = '0;
                    my_nxt = my_cur + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = issue_last ? DRAIN : RUN;
            RUN:     if (issue_last || abort_stop) state_nxt = DRAIN;
            DRAIN:   if (!vld_p0 && !vld_p1) state_nxt = DONE;
            DONE:    if (!req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) || (state == DRAIN);
        ack  = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx <= '0;
            ty <= '0;
            mx <= '0;
            my <= '0;
        end else if (issue) begin
            tx <= tx_nxt;
            ty <= ty_nxt;
            mx <= mx_nxt;
            my <= my_nxt;
        end else if (state == IDLE) begin
            tx <= '0;
            ty <= '0;
            mx <= '0;
            my <= '0;
        end
    end

    // Stage p0: registered read addresses with their candidate tags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            addr_sw <= '0;
            addr_tb <= '0;
        end else begin
            vld_p0 <= issue;
            if (issue) begin
                addr_tb <= ADDR_TB'(32'(ty_cur) * TB_LENGTH + 32'(tx_cur));
                addr_sw <= ADDR_SW'((32'(my_cur) + 32'(ty_cur)) * SW_LENGTH
                                    + 32'(mx_cur) + 32'(tx_cur));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            first_p0 <= (tx_cur == '0) && (ty_cur == '0);
            last_p0  <= pix_last;
            mvx_p0   <= mx_cur;
            mvy_p0   <= my_cur;
        end
    end

    // Stage p1: read data returns; an aborted candidate's in-flight read is dropped here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0 && !abort;
            vld_p2 <= vld_p1 && last_p1;
        end
    end

    always_ff @(posedge clk) begin
        first_p1 <= first_p0;
        last_p1  <= last_p0;
        mvx_p1   <= mvx_p0;
        mvy_p1   <= mvy_p0;
        if (vld_p1) begin
            acc_p2 <= partial_p1;
        end
        if (vld_p1 && last_p1) begin
            mvx_p2 <= mvx_p1;
            mvy_p2 <= mvy_p1;
        end
    end

    // Stage p2: completed SAD against the minimum; strict compare keeps the earliest tie.
    assign upd = vld_p2 && (!min_valid || (acc_p2 < min_sad));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            min_valid <= 1'b0;
            min_sad   <= '0;
            min_mvx   <= '0;
            min_mvy   <= '0;
        end else if (start) begin
            min_valid <= 1'b0;
        end else if (upd) begin
            min_valid <= 1'b1;
            min_sad   <= acc_p2;
            min_mvx   <= mvx_p2;
            min_mvy   <= mvy_p2;
        end
    end

endmodule
